cpu_control_unit: RTL

CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

---
 rtl/cpu_control_unit_if.sv | 13 +
 rtl/cpu_control_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit_if.sv
// Instruction-fetch bus between the control unit (master) and instruction memory (slave).
interface cpu_control_unit_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned INST_W = 32
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [INST_W-1:0] mem_rdata;

    modport master (output mem_rd, output mem_addr, input mem_valid, input mem_rdata);
    modport slave  (input mem_rd, input mem_addr, output mem_valid, output mem_rdata);
endinterface

// File: rtl/cpu_control_unit.sv
// Fetch/execute sequencer with one-hot micro-step counter, halt and sticky fault states.
// Define CPU_CALL_STACK_EN to add a STACK_DEPTH-entry return-address stack for call/ret.
module cpu_control_unit #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned INST_W      = 32,
    parameter int unsigned STEPS       = 16,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    cpu_control_unit_if.master  bus,
    input  logic                end_inst,
    input  logic                inst_condition,
    input  logic                jmp_inst,
    input  logic                call_inst,
    input  logic                ret_inst,
    input  logic                hlt_inst,
    input  logic [ADDR_W-1:0]   jmp_address,
    input  logic                resume,
    output logic [INST_W-1:0]   ir,
    output logic [STEPS-1:0]    steps,
    output logic [ADDR_W-1:0]   pc,
    output logic [1:0]          state,
    output logic                fault,
    output logic [1:0]          fault_code
);

    typedef enum logic [1:0] {StFetch = 2'd0, StExec = 2'd1, StHalt = 2'd2, StFault = 2'd3} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d, pc_inc;
    logic [INST_W-1:0]   ir_q, ir_d;
    logic [STEPS-1:0]    steps_q, steps_d;
    logic [1:0]          fault_code_q, fault_code_d;
    logic                retire;

    assign pc_inc = pc_q + ADDR_W'(1);
    assign retire = end_inst || !inst_condition;

`ifdef CPU_CALL_STACK_EN
    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
    localparam int unsigned SP_W  = IDX_W + 1;

    logic [SP_W-1:0]   sp_q, sp_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [IDX_W-1:0]  idx, top;
    logic              push;

    assign idx = sp_q[IDX_W-1:0];
    assign top = idx - IDX_W'(1);

    always_ff @(posedge clk) begin
        if (push) stack_q[idx] <= pc_inc;
    end
`else
    logic unused_ret;
    assign unused_ret = ret_inst;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        steps_d      = steps_q;
        fault_code_d = fault_code_q;
`ifdef CPU_CALL_STACK_EN
        sp_d         = sp_q;
        push         = 1'b0;
`endif
        unique case (state_q)
            StFetch: begin
                if (bus.mem_valid) begin
                    ir_d    = bus.mem_rdata;
                    steps_d = STEPS'(1);
                    state_d = StExec;
                end
            end
            StExec: begin
                if (retire) begin
                    steps_d = '0;
                    state_d = hlt_inst ? StHalt : StFetch;
`ifdef CPU_CALL_STACK_EN
                    // Stack faults override the halt/fetch choice and leave pc alone.
                    if (ret_inst) begin
                        if (sp_q == '0) begin
                            state_d      = StFault;
                            fault_code_d = 2'd3;
                        end else begin
                            pc_d = stack_q[top];
                            sp_d = sp_q - SP_W'(1);
                        end
                    end else if (call_inst) begin
                        if (sp_q == SP_W'(STACK_DEPTH)) begin
                            state_d      = StFault;
                            fault_code_d = 2'd2;
                        end else begin
                            push = 1'b1;
                            sp_d = sp_q + SP_W'(1);
                            pc_d = jmp_address;
                        end
                    end else if (jmp_inst) begin
                        pc_d = jmp_address;
                    end else begin
                        pc_d = pc_inc;
                    end
`else
                    pc_d = (call_inst || jmp_inst) ? jmp_address : pc_inc;
`endif
                end else if (steps_q[STEPS-1]) begin
                    state_d      = StFault;
                    fault_code_d = 2'd1;
                end else begin
                    steps_d = steps_q << 1;
                end
            end
            StHalt: begin
                if (resume) state_d = StFetch;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StFetch;
            pc_q         <= '0;
            ir_q         <= '0;
            steps_q      <= '0;
            fault_code_q <= '0;
`ifdef CPU_CALL_STACK_EN
            sp_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            steps_q      <= steps_d;
            fault_code_q <= fault_code_d;
`ifdef CPU_CALL_STACK_EN
            sp_q         <= sp_d;
`endif
        end
    end

    assign bus.mem_rd   = (state_q == StFetch);
    assign bus.mem_addr = pc_q;
    assign ir           = ir_q;
    assign steps        = steps_q;
    assign pc           = pc_q;
    assign state        = state_q;
    assign fault        = (state_q == StFault);
    assign fault_code   = fault_code_q;

endmodule
